// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// ClkDivCtrl (module clk_div_ctrl)
//
// Runtime-programmable clock divider with a small sequencing controller.
// A host writes divide ratios and start/stop requests over a valid/ready
// interface. Every change takes effect only on a half-period boundary, so the
// divided clock never shows a runt or glitch pulse. The only exception is an
// asynchronous reset, which forces everything back to idle at once.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   cfg_valid   config request valid
//   cfg_ready   controller can accept a request (STOPPED or RUN)
//   cfg_enable  1 = run with cfg_half, 0 = stop after a full high phase
//   cfg_half    requested half-period in clk cycles (0 is treated as 1)
//   out         divided clock, registered
//   tick        one-cycle pulse in the first high cycle of out
//   running     high whenever the divider is not STOPPED
//   edge_count  (optional) saturating count of out rising edges
//
// Optional feature macro: CLK_DIV_CTRL_EDGE_CNT_EN
//   When defined, the edge_count output and its counter are built in.
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int DIV_WIDTH    = 24,
  parameter int DEFAULT_HALF = 6000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_enable,
  input  logic [DIV_WIDTH-1:0] cfg_half,
  output logic                 out,
  output logic                 tick,
  output logic                 running
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
  ,
  output logic [15:0]          edge_count
`endif
);

  localparam logic [DIV_WIDTH-1:0] ONE_W     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DEFAULT_W = DIV_WIDTH'(DEFAULT_HALF);

  // STOPPED: idle, out low. RUN: dividing, accepting requests.
  // PEND: a new ratio waits for the next boundary. DRAIN: finishing the
  // current cycle so the final high phase is full length.
  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    PEND    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 out_q, out_d;
  logic                 tick_q, tick_d;
  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] half_q, half_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;

  logic                 xfer;
  logic                 boundary;
  logic [DIV_WIDTH-1:0] halfReq;

  // Handshake and status are pure decodes of the state register, so they
  // change exactly when the state does and cannot disagree with it.
  assign cfg_ready = (state_q == STOPPED) || (state_q == RUN);
  assign running   = (state_q != STOPPED);
  assign out       = out_q;
  assign tick      = tick_q;

  assign xfer     = cfg_valid && cfg_ready;
  assign halfReq  = (cfg_half == '0) ? ONE_W : cfg_half;
  // A boundary is the last cycle of a half-period. It only exists while the
  // divider is active; in STOPPED the counter is parked at zero.
  assign boundary = (state_q != STOPPED) && (count_q == (half_q - ONE_W));

  // Next-state logic. The counter and out toggling are shared by every
  // active state; the case statement only decides where the ratio and the
  // state go. A request arriving on a boundary still lets that boundary run
  // with the old ratio; the request is serviced at the following boundary.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    count_d = count_q;
    half_d  = half_q;
    pend_d  = pend_q;

    if (state_q != STOPPED) begin
      if (boundary) begin
        out_d   = ~out_q;
        tick_d  = ~out_q;
        count_d = '0;
      end else begin
        count_d = count_q + ONE_W;
      end
    end

    case (state_q)
      STOPPED: begin
        out_d   = 1'b0;
        count_d = '0;
        if (xfer && cfg_enable) begin
          half_d  = halfReq;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (cfg_enable) begin
            pend_d  = halfReq;
            state_d = PEND;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      PEND: begin
        if (boundary) begin
          half_d  = pend_q;
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (boundary && out_q) begin
          state_d = STOPPED;
        end
      end
      default: begin
        state_d = STOPPED;
      end
    endcase
  end

  // Single state register for the controller and its registered outputs.
  // Reset is asynchronous so out drops immediately, without waiting for a
  // boundary, and any pending request is thrown away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STOPPED;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
      count_q <= '0;
      half_q  <= DEFAULT_W;
      pend_q  <= DEFAULT_W;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      half_q  <= half_d;
      pend_q  <= pend_d;
    end
  end

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
  logic [15:0] edgeCnt_q, edgeCnt_d;
  logic        riseEvent;

  assign riseEvent  = boundary && !out_q;
  assign edge_count = edgeCnt_q;

  // Rising-edge counter. A start/retune request restarts the count; if that
  // request lands on the same cycle as a rising edge, the clear wins so the
  // count describes only edges produced under the new setting.
  always_comb begin
    edgeCnt_d = edgeCnt_q;
    if (xfer && cfg_enable) begin
      edgeCnt_d = '0;
    end else if (riseEvent && (edgeCnt_q != 16'hFFFF)) begin
      edgeCnt_d = edgeCnt_q + 16'd1;
    end
  end

  // Edge counter register, cleared by the same asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edgeCnt_q <= '0;
    end else begin
      edgeCnt_q <= edgeCnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for clk_div_ctrl. Expected output vectors {out,tick,running,
// cfg_ready} are pushed onto a scoreboard queue as each directed step is
// driven, then popped and compared on the falling edge after every clock.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int DW = 8;
  localparam int DH = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid;
  logic          cfg_enable;
  logic [DW-1:0] cfg_half;
  logic          cfg_ready;
  logic          out;
  logic          tick;
  logic          running;
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
  logic [15:0]   edge_count;
`endif

  int            assertCount = 0;
  int            failCount   = 0;
  int            cycleNum    = 0;
  string         tag         = "init";
  logic [3:0]    expQ[$];

  clk_div_ctrl #(
    .DIV_WIDTH   (DW),
    .DEFAULT_HALF(DH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_enable(cfg_enable),
    .cfg_half  (cfg_half),
    .out       (out),
    .tick      (tick),
    .running   (running)
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    ,
    .edge_count(edge_count)
`endif
  );

  // Free-running system clock, 10 time units per period.
  always #5 clk = ~clk;

  // Drive the config interface.
  task automatic applyStimulus(input logic v, input logic en, input logic [DW-1:0] h);
    cfg_valid  = v;
    cfg_enable = en;
    cfg_half   = h;
  endtask

  // Push len expected cycles of one phase of out; a high phase carries tick
  // in its first cycle only.
  task automatic expectPhase(input logic o, input int len, input logic run, input logic rdy);
    for (int i = 0; i < len; i++) begin
      expQ.push_back({o, (i == 0) && o, run, rdy});
    end
  endtask

  // Pop one expected vector and compare it against the live outputs.
  task automatic checkOutput();
    logic [3:0] e;
    logic [3:0] obs;
    assertCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL %s cyc=%0d scoreboard empty", tag, cycleNum);
      return;
    end
    e   = expQ.pop_front();
    obs = {out, tick, running, cfg_ready};
    assert (obs === e) else begin
      failCount++;
      $error("[TB] FAIL %s cyc=%0d {out,tick,running,ready} observed=%b expected=%b",
             tag, cycleNum, obs, e);
    end
  endtask

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
  task automatic checkEdgeCount(input logic [15:0] e);
    assertCount++;
    assert (edge_count === e) else begin
      failCount++;
      $error("[TB] FAIL %s edge_count observed=%0d expected=%0d", tag, edge_count, e);
    end
  endtask
`endif

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    cycleNum++;
    checkOutput();
  endtask

  task automatic drainQueue();
    while (expQ.size() > 0) stepCycle();
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, '0);

    // Reset state while rst is held.
    #1;
    tag = "reset-hold";
    expQ.push_back(4'b0001);
    checkOutput();
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    checkEdgeCount(16'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle with no config: stays stopped and ready.
    tag = "idle";
    expectPhase(1'b0, 20, 1'b0, 1'b1);
    drainQueue();

    // Enable with half=3: low 3, high 3, period 6.
    tag = "enable3";
    applyStimulus(1'b1, 1'b1, 8'd3);
    expectPhase(1'b0, 3, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0);
    expectPhase(1'b1, 3, 1'b1, 1'b1);
    expectPhase(1'b0, 3, 1'b1, 1'b1);
    expectPhase(1'b1, 3, 1'b1, 1'b1);
    drainQueue();
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    checkEdgeCount(16'd2);
`endif

    // Retune to 5 mid-phase: current low phase still lasts 3, then 5s.
    tag = "retune5";
    expQ.push_back(4'b0011);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 8'd5);
    expQ.push_back(4'b0010);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0);
    expQ.push_back(4'b0010);
    expectPhase(1'b1, 5, 1'b1, 1'b1);
    expectPhase(1'b0, 5, 1'b1, 1'b1);
    expectPhase(1'b1, 5, 1'b1, 1'b1);
    drainQueue();

    // Retune to 3 exactly on a boundary: next phase still uses 5.
    tag = "retune-on-boundary";
    applyStimulus(1'b1, 1'b1, 8'd3);
    expectPhase(1'b0, 5, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0);
    expectPhase(1'b1, 3, 1'b1, 1'b1);
    expectPhase(1'b0, 2, 1'b1, 1'b1);
    drainQueue();

    // Disable mid low phase: finish low, full high, then stop low.
    tag = "disable";
    applyStimulus(1'b1, 1'b0, '0);
    expQ.push_back(4'b0010);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0);
    expectPhase(1'b1, 3, 1'b1, 1'b0);
    expectPhase(1'b0, 5, 1'b0, 1'b1);
    drainQueue();

    // cfg_half=0 behaves as 1: toggle every cycle.
    tag = "half0";
    applyStimulus(1'b1, 1'b1, 8'd0);
    expectPhase(1'b0, 1, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      expectPhase(1'b1, 1, 1'b1, 1'b1);
      expectPhase(1'b0, 1, 1'b1, 1'b1);
    end
    drainQueue();

    // Enter PEND with out high, then reset asynchronously mid-cycle.
    tag = "pend-high";
    applyStimulus(1'b1, 1'b1, 8'd4);
    expQ.push_back(4'b1110);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    tag = "reset-immediate";
    expQ.push_back(4'b0001);
    checkOutput();
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    checkEdgeCount(16'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Pending request discarded: remains stopped.
    tag = "after-reset";
    expectPhase(1'b0, 4, 1'b0, 1'b1);
    drainQueue();

    // Clean restart with half=2.
    tag = "restart2";
    applyStimulus(1'b1, 1'b1, 8'd2);
    expectPhase(1'b0, 2, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0);
    expectPhase(1'b1, 2, 1'b1, 1'b1);
    expectPhase(1'b0, 2, 1'b1, 1'b1);
    drainQueue();
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    checkEdgeCount(16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Runtime-programmable clock divider with a sequencing controller. It accepts divide-ratio and enable/disable requests over a valid/ready config interface. New settings are applied only at half-period boundaries, so `out` never produces a runt or glitch pulse. It sits between a host/config block and downstream logic that needs a slow square wave and a rising-edge tick.

Parameters:
- DIV_WIDTH, 24, width of the half-period count and of the config value.
- DEFAULT_HALF, 6000000, half-period (clk cycles) loaded at reset; must fit in DIV_WIDTH and be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- cfg_valid  input  1  config request valid.
- cfg_ready  output  1  controller can accept a config request.
- cfg_enable  input  1  1 = run with cfg_half; 0 = stop.
- cfg_half  input  DIV_WIDTH  requested half-period in clk cycles; 0 is treated as 1.
- out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse, high in the same cycle `out` is first high after a 0->1 transition.
- running  output  1  high in RUN, PEND or DRAIN.

Behaviour:
- Reset values: state=STOPPED, out=0, tick=0, count=0, half_reg=DEFAULT_HALF, pend_reg=DEFAULT_HALF, cfg_ready=1, running=0.
- Handshake:
  - A transfer occurs on a clk edge when cfg_valid && cfg_ready.
  - cfg_ready=1 in STOPPED and RUN; 0 in PEND and DRAIN.
  - cfg_valid may be held high while cfg_ready is low; no transfer occurs until cfg_ready rises.
- Boundary:
  - Boundary condition: count == half_reg-1 in RUN, PEND or DRAIN.
  - On a boundary: out toggles, count <= 0.
  - Otherwise count <= count+1.
  - With half_reg=1, out toggles every cycle.
- STOPPED:
  - out held 0, count held 0.
  - Transfer with cfg_enable=1: half_reg <= max(cfg_half,1), count <= 0, go RUN. First toggle lands half_reg cycles after the transfer edge.
  - Transfer with cfg_enable=0: accepted, no effect.
- RUN:
  - Transfer with cfg_enable=1: pend_reg <= max(cfg_half,1), go PEND.
  - Transfer with cfg_enable=0: go DRAIN.
  - If the transfer coincides with a boundary, that boundary uses the old half_reg. The request is serviced at the following boundary.
- PEND:
  - Counting continues with the old half_reg.
  - At the boundary: toggle, half_reg <= pend_reg, go RUN.
  - The new ratio governs the very next half-period.
- DRAIN:
  - Counting continues.
  - At a boundary where out is 1 (toggling to 0): go STOPPED.
  - At a boundary where out is 0: toggle to 1, raise tick, stay in DRAIN.
  - Result: the last high phase is always full length and `out` ends low.
- tick: registered; asserted exactly one cycle, coincident with out's first high cycle. Never asserted in STOPPED.
- running: combinational decode of state != STOPPED.
- Reset mid-operation: all state returns to reset values immediately (async). Any pending request is discarded. out drops to 0 without waiting for a boundary; this is the only permitted short pulse.
- Arithmetic: count and half_reg are DIV_WIDTH bits with no wrap; count never exceeds half_reg-1.

Optional Feature:
- Macro: CLK_DIV_CTRL_EDGE_CNT_EN.
- When defined:
  - Adds output port edge_count [15:0], counting out rising edges.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on reset and on every accepted transfer with cfg_enable=1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with DEFAULT_HALF=3, no config -> out=0, tick=0, running=0, cfg_ready=1 for 20 cycles.
- Enable, half=3 at cycle T -> out rises at T+3, falls at T+6, period 6; tick high only at T+3, T+9, ...; running=1 from T+1.
- In RUN half=3, request half=5 mid-phase -> cfg_ready low until the next boundary; that boundary lands 3 cycles after the previous one, then phases of 5 cycles; no phase of other length.
- Disable while out=0 mid-phase -> out completes a full 3-cycle low phase and a full 3-cycle high phase, then stays 0; state STOPPED; cfg_ready returns high.
- cfg_half=0 enable -> out toggles every cycle (period 2); tick every 2 cycles.
- Assert rst while out=1 in PEND -> out=0 and cfg_ready=1 immediately; half_reg=DEFAULT_HALF; with the macro defined, edge_count=0.
